// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_cfg
// Brief    : Parametrised UART receiver with input synchroniser, false-start
//            rejection, parity/framing/overrun flags and break handling.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
  parameter int CLK_DIV    = 2604,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX,
  input  logic                 clr_rdy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rdy,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int               CNT_W       = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] c_half_load = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] c_full_load = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
  localparam logic [3:0]       c_last_data = 4'(DATA_BITS - 1);
  localparam logic             c_last_stop = 1'(STOP_BITS - 1);
  localparam logic             c_par_en    = 1'(PARITY_EN);
  localparam logic             c_par_odd   = 1'(PARITY_ODD);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_start  = 3'd1;
  localparam logic [2:0] c_st_data   = 3'd2;
  localparam logic [2:0] c_st_parity = 3'd3;
  localparam logic [2:0] c_st_stop   = 3'd4;
  localparam logic [2:0] c_st_brk    = 3'd5;

  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rdy_q, rdy_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  logic w_fall;
  logic w_tick;
  logic w_done;

  assign w_fall = rx_prev_q & ~rx_sync_q;
  assign w_tick = (cnt_q == '0);
  assign w_done = (state_q == c_st_stop) && w_tick && (stop_q == c_last_stop);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= c_st_idle;
      cnt_q        <= '0;
      bit_q        <= '0;
      stop_q       <= 1'b0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      rx_data_q    <= '0;
      rdy_q        <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_meta_q    <= RX;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      stop_q       <= stop_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      rx_data_q    <= rx_data_d;
      rdy_q        <= rdy_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle:   if (w_fall) state_d = c_st_start;
      c_st_start:  if (w_tick) state_d = rx_sync_q ? c_st_idle : c_st_data;
      c_st_data:   if (w_tick && (bit_q == c_last_data))
                     state_d = c_par_en ? c_st_parity : c_st_stop;
      c_st_parity: if (w_tick) state_d = c_st_stop;
      c_st_stop:   if (w_done) state_d = rx_sync_q ? c_st_idle : c_st_brk;
      c_st_brk:    if (rx_sync_q) state_d = c_st_idle;
      default:     state_d = c_st_idle;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    stop_d       = stop_q;
    shift_d      = shift_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    rx_data_d    = rx_data_q;
    rdy_d        = rdy_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;

    if (state_q == c_st_idle) begin
      if (w_fall) cnt_d = c_half_load;
    end else if (state_q != c_st_brk) begin
      cnt_d = w_tick ? c_full_load : (cnt_q - c_cnt_one);
    end

    if (w_tick) begin
      case (state_q)
        c_st_start: begin
          bit_d  = '0;
          stop_d = 1'b0;
          perr_d = 1'b0;
          ferr_d = 1'b0;
        end
        c_st_data: begin
          shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 4'd1;
        end
        c_st_parity: perr_d = ((^shift_q) ^ rx_sync_q) != c_par_odd;
        c_st_stop: begin
          stop_d = stop_q + 1'b1;
          if (!rx_sync_q) ferr_d = 1'b1;
        end
        default: ;
      endcase
    end

    // A completing frame takes priority over a simultaneous clear
    if (w_done) begin
      rx_data_d    = shift_q;
      rdy_d        = 1'b1;
      parity_err_d = perr_q;
      frame_err_d  = ferr_q | ~rx_sync_q;
      overrun_d    = rdy_q & ~clr_rdy;
    end else if (clr_rdy) begin
      rdy_d        = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      overrun_d    = 1'b0;
    end
  end

  assign rx_data    = rx_data_q;
  assign rdy        = rdy_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule
`default_nettype wire
